// File: rtl/sha256_w_stream_reader.sv
// Streams W_0..W_(NUM_WORDS-1) for one captured 512-bit block over valid/ready.
// W_0..W_15 come from the block register; later words come from the external expander window.
module sha256_w_stream_reader #(
   parameter int unsigned NUM_WORDS = 64
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [511:0] block_in,
   input  logic [127:0] window_in,
   output logic [127:0] window_out,
   output logic         mem_write_en,
   output logic [31:0]  w_out,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [5:0]   w_index,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {S_IDLE, S_MSG, S_EXP, S_DONE} state_t;

   localparam logic [5:0] LAST_T = 6'(NUM_WORDS - 1);

   state_t      state;
   logic [5:0]  t;
   logic [31:0] blk [16];
   logic        w_valid_q;
   logic        busy_q;
   logic        done_q;
   logic        fire;

   // A reset cycle never counts as a fire, so no expander step leaks out of it.
   assign fire    = w_valid_q & w_ready & ~RST;
   assign w_valid = w_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign w_index = t;

   always_comb begin
      w_out        = '0;
      window_out   = '0;
      mem_write_en = 1'b0;
      case (state)
         S_MSG: begin
            w_out = blk[t[3:0]];
            // Seed step shares the cycle with the W_15 fire.
            if (fire && t == 6'd15) begin
               mem_write_en = 1'b1;
               window_out   = {blk[12], blk[13], blk[14], blk[15]};
            end
         end
         S_EXP: begin
            w_out        = window_in[31:0];
            window_out   = window_in;
            mem_write_en = fire && (t != LAST_T);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         t         <= '0;
         w_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) begin
            blk[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int unsigned i = 0; i < 16; i++) begin
                     blk[i] <= block_in[511 - 32*i -: 32];
                  end
                  t         <= '0;
                  state     <= S_MSG;
                  w_valid_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_MSG: begin
               if (fire) begin
                  t <= t + 6'd1;
                  if (t == 6'd15) begin
                     state <= S_EXP;
                  end
               end
            end
            S_EXP: begin
               if (fire) begin
                  if (t == LAST_T) begin
                     state     <= S_DONE;
                     w_valid_q <= 1'b0;
                     done_q    <= 1'b1;
                  end else begin
                     t <= t + 6'd1;
                  end
               end
            end
            S_DONE: begin
               t      <= '0;
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Scoreboard bench: a FIPS 180-4 schedule model feeds expected words and emulates the expander.
// Instance 0 uses NUM_WORDS=64, instance 1 uses NUM_WORDS=17.
module tb_sha256_w_stream_reader;

   typedef struct packed {
      logic [31:0] w;
      logic [5:0]  idx;
   } exp_t;

   typedef enum {P_IDLE, P_STREAM, P_DONE} ph_t;

   logic         CLK;
   logic         rst      [2];
   logic         start    [2];
   logic [511:0] block_in [2];
   logic [127:0] win      [2];
   logic [127:0] win_nxt  [2];
   logic [127:0] win_o    [2];
   logic         mwe      [2];
   logic [31:0]  w_out    [2];
   logic         w_valid  [2];
   logic         w_ready  [2];
   logic [5:0]   w_index  [2];
   logic         busy     [2];
   logic         done     [2];

   int checks   = 0;
   int failures = 0;
   int tot_wr  [2];
   int wcnt    [2];
   int rem     [2];
   int stall_wr = 0;
   bit mon_en   = 0;

   ph_t         ph [2];
   exp_t        exp_q [2][$];
   logic [31:0] sched [2][64];

   localparam logic [511:0] ABC_BLOCK = {32'h61626380, 416'h0, 64'h18};

   sha256_w_stream_reader #(.NUM_WORDS(64)) dut (
      .CLK(CLK), .RST(rst[0]), .start(start[0]), .block_in(block_in[0]),
      .window_in(win[0]), .window_out(win_o[0]), .mem_write_en(mwe[0]),
      .w_out(w_out[0]), .w_valid(w_valid[0]), .w_ready(w_ready[0]),
      .w_index(w_index[0]), .busy(busy[0]), .done(done[0])
   );

   sha256_w_stream_reader #(.NUM_WORDS(17)) dut17 (
      .CLK(CLK), .RST(rst[1]), .start(start[1]), .block_in(block_in[1]),
      .window_in(win[1]), .window_out(win_o[1]), .mem_write_en(mwe[1]),
      .w_out(w_out[1]), .w_valid(w_valid[1]), .w_ready(w_ready[1]),
      .w_index(w_index[1]), .busy(busy[1]), .done(done[1])
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int nw(input int i);
      return (i == 0) ? 64 : 17;
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic load_sched(input int i, input logic [511:0] b);
      for (int k = 0; k < 16; k++) sched[i][k] = b[511 - 32*k -: 32];
      for (int k = 16; k < 64; k++)
         sched[i][k] = ssig1(sched[i][k-2]) + sched[i][k-7] + ssig0(sched[i][k-15]) + sched[i][k-16];
   endtask

   task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, i, $time, act, req);
      end
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom;
      return b;
   endfunction

   // Expander register emulation: the step computed mid-cycle lands on the next rising edge.
   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) win[i] <= win_nxt[i];
   end

   // Monitor: compares outputs against the reference, then advances it using the sampled inputs.
   always @(negedge CLK) begin
      exp_t e;
      logic fire_c;
      logic wr_exp;
      int   m;
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            fire_c = w_valid[i] && w_ready[i];
            chk("w_valid", i, 128'(w_valid[i]), 128'(ph[i] == P_STREAM));
            chk("busy", i, 128'(busy[i]), 128'(ph[i] != P_IDLE));
            chk("done", i, 128'(done[i]), 128'(ph[i] == P_DONE));
            if (mwe[i]) tot_wr[i]++;
            if (mwe[i] && !fire_c) stall_wr++;
            if (ph[i] == P_IDLE) begin
               chk("idle_w_out", i, 128'(w_out[i]), 128'(0));
               chk("idle_w_index", i, 128'(w_index[i]), 128'(0));
               chk("idle_window_out", i, win_o[i], 128'(0));
               chk("idle_mwe", i, 128'(mwe[i]), 128'(0));
            end else if (ph[i] == P_DONE) begin
               chk("done_mwe", i, 128'(mwe[i]), 128'(0));
            end else if (exp_q[i].size() == 0) begin
               chk("queue_empty", i, 128'(1), 128'(0));
            end else begin
               e = exp_q[i][0];
               chk("w_out", i, 128'(w_out[i]), 128'(e.w));
               chk("w_index", i, 128'(w_index[i]), 128'(e.idx));
               wr_exp = fire_c && !rst[i] && (e.idx >= 6'd15) && (int'(e.idx) <= nw(i) - 2);
               chk("mem_write_en", i, 128'(mwe[i]), 128'(wr_exp));
               if (mwe[i]) begin
                  m = wcnt[i];
                  if (m + 16 > 63) begin
                     chk("extra_write", i, 128'(m), 128'(47));
                  end else begin
                     chk("window_out_write", i, win_o[i],
                         {sched[i][12+m], sched[i][13+m], sched[i][14+m], sched[i][15+m]});
                     win_nxt[i] = {sched[i][13+m], sched[i][14+m], sched[i][15+m], sched[i][16+m]};
                     wcnt[i]++;
                  end
               end else if (e.idx <= 6'd15) begin
                  chk("window_out_msg", i, win_o[i], 128'(0));
               end else begin
                  chk("window_out_exp", i, win_o[i], win[i]);
               end
               if (fire_c && !rst[i]) begin
                  void'(exp_q[i].pop_front());
                  rem[i]--;
               end
            end
            if (rst[i]) begin
               ph[i] = P_IDLE;
               exp_q[i].delete();
            end else begin
               case (ph[i])
                  P_IDLE: if (start[i]) begin
                     load_sched(i, block_in[i]);
                     for (int k = 0; k < nw(i); k++) exp_q[i].push_back('{w: sched[i][k], idx: 6'(k)});
                     wcnt[i] = 0;
                     rem[i]  = nw(i);
                     ph[i]   = P_STREAM;
                  end
                  P_STREAM: if (rem[i] == 0) ph[i] = P_DONE;
                  default: ph[i] = P_IDLE;
               endcase
            end
         end
      end
   end

   task automatic run_block(input int i, input logic [511:0] b, input int mode, output int cycles);
      int stalls;
      stalls      = 0;
      block_in[i] = b;
      start[i]    = 1'b1;
      w_ready[i]  = 1'b1;
      @(posedge CLK); #1;
      start[i] = 1'b0;
      cycles   = 0;
      while (!done[i] && cycles < 400) begin
         case (mode)
            0: w_ready[i] = 1'b1;
            1: w_ready[i] = ($urandom_range(1) == 1);
            default: begin
               if (w_valid[i] && w_index[i] == 6'd15 && stalls < 5) begin
                  w_ready[i] = 1'b0;
                  stalls++;
               end else begin
                  w_ready[i] = 1'b1;
               end
            end
         endcase
         @(posedge CLK); #1;
         cycles++;
      end
      chk("done_seen", i, 128'(done[i]), 128'(1));
      w_ready[i] = 1'b1;
      @(posedge CLK); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog inst0 actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int w0;
      int guard;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; w_ready[i] = 1'b0;
         block_in[i] = rand_block();
         win[i] = '0; win_nxt[i] = '0;
         ph[i] = P_IDLE; tot_wr[i] = 0; wcnt[i] = 0; rem[i] = 0;
      end
      repeat (2) @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0;
         chk("rst_w_valid", i, 128'(w_valid[i]), 128'(0));
         chk("rst_busy", i, 128'(busy[i]), 128'(0));
         chk("rst_done", i, 128'(done[i]), 128'(0));
         chk("rst_mwe", i, 128'(mwe[i]), 128'(0));
         chk("rst_window_out", i, win_o[i], 128'(0));
         chk("rst_w_out", i, 128'(w_out[i]), 128'(0));
         chk("rst_w_index", i, 128'(w_index[i]), 128'(0));
      end
      mon_en = 1;

      // FIPS "abc" block, full throughput
      run_block(0, ABC_BLOCK, 0, cyc);
      chk("throughput_cycles", 0, 128'(cyc), 128'(64));

      // random back-pressure
      w0 = tot_wr[0];
      run_block(0, ABC_BLOCK, 1, cyc);
      chk("writes_per_block", 0, 128'(tot_wr[0] - w0), 128'(48));
      run_block(0, rand_block(), 1, cyc);

      // start held high: second block only after done, first stream untouched
      block_in[0] = rand_block();
      start[0]    = 1'b1;
      w_ready[0]  = 1'b1;
      @(posedge CLK); #1;
      block_in[0] = rand_block();
      guard = 0;
      while (!done[0] && guard < 400) begin @(posedge CLK); #1; guard++; end
      chk("held_done1", 0, 128'(done[0]), 128'(1));
      @(posedge CLK); #1;
      chk("held_idle_gap", 0, 128'(busy[0]), 128'(0));
      @(posedge CLK); #1;
      start[0] = 1'b0;
      block_in[0] = rand_block();
      guard = 0;
      while (!done[0] && guard < 400) begin @(posedge CLK); #1; guard++; end
      chk("held_done2", 0, 128'(done[0]), 128'(1));
      @(posedge CLK); #1;

      // reset in EXP at t=30, then clean restart
      block_in[0] = rand_block();
      start[0] = 1'b1;
      @(posedge CLK); #1;
      start[0] = 1'b0;
      guard = 0;
      while (!(w_valid[0] && w_index[0] == 6'd30) && guard < 100) begin @(posedge CLK); #1; guard++; end
      chk("reach_t30", 0, 128'(w_index[0]), 128'(30));
      rst[0] = 1'b1;
      @(posedge CLK); #1;
      rst[0] = 1'b0;
      chk("post_rst_w_valid", 0, 128'(w_valid[0]), 128'(0));
      chk("post_rst_busy", 0, 128'(busy[0]), 128'(0));
      chk("post_rst_mwe", 0, 128'(mwe[0]), 128'(0));
      run_block(0, rand_block(), 0, cyc);

      // stall at t=15 for five cycles
      w0 = tot_wr[0];
      run_block(0, rand_block(), 2, cyc);
      chk("stall_cycles", 0, 128'(cyc), 128'(69));
      chk("stall_writes_per_block", 0, 128'(tot_wr[0] - w0), 128'(48));

      // NUM_WORDS=17
      run_block(1, ABC_BLOCK, 0, cyc);
      chk("nw17_cycles", 1, 128'(cyc), 128'(17));
      chk("nw17_writes", 1, 128'(tot_wr[1]), 128'(1));
      run_block(1, rand_block(), 1, cyc);
      chk("nw17_writes_total", 1, 128'(tot_wr[1]), 128'(2));

      repeat (3) @(posedge CLK);
      #1;
      chk("stall_writes", 0, 128'(stall_wr), 128'(0));
      chk("queue_drained", 0, 128'(exp_q[0].size()), 128'(0));
      chk("queue_drained", 1, 128'(exp_q[1].size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
